// File: rtl/serial_word_adder_if.sv
// Operand/result handshake bundle for serial_word_adder.
// With SERIAL_WORD_ADDER_SUB_EN defined, the bundle also carries up_sub.
interface serial_word_adder_if #(
  parameter int W = 8
);
  logic         up_valid;
  logic         up_ready;
  logic [W-1:0] up_a;
  logic [W-1:0] up_b;
`ifdef SERIAL_WORD_ADDER_SUB_EN
  logic         up_sub;
`endif
  logic         down_valid;
  logic         down_ready;
  logic [W-1:0] down_sum;
  logic         down_carry;

`ifdef SERIAL_WORD_ADDER_SUB_EN
  modport master (
    output up_valid, up_a, up_b, up_sub, down_ready,
    input  up_ready, down_valid, down_sum, down_carry
  );
  modport slave (
    input  up_valid, up_a, up_b, up_sub, down_ready,
    output up_ready, down_valid, down_sum, down_carry
  );
`else
  modport master (
    output up_valid, up_a, up_b, down_ready,
    input  up_ready, down_valid, down_sum, down_carry
  );
  modport slave (
    input  up_valid, up_a, up_b, down_ready,
    output up_ready, down_valid, down_sum, down_carry
  );
`endif
endinterface

// File: rtl/serial_word_adder.sv
// Parallel-in/parallel-out wrapper around a bit-serial full adder (LSB first, W cycles).
// Optional SERIAL_WORD_ADDER_SUB_EN: up_sub=1 computes A-B (down_carry=1 means no borrow).
module serial_word_adder #(
  parameter int W = 8
) (
  input logic                clk,
  input logic                rst,
  serial_word_adder_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_a_sr;
  logic [W-1:0]  r_b_sr;
  logic [W-2:0]  r_sum_sr;
  logic [W-1:0]  r_down_sum;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic          r_down_carry;
  logic          r_up_ready;
  logic          r_down_valid;
  logic          w_s;
  logic          w_c;
  logic          w_accept;
  logic          w_last;
  logic [W-1:0]  w_sum_cat;
  logic [W-1:0]  w_b_load;
  logic          w_carry_init;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

`ifdef SERIAL_WORD_ADDER_SUB_EN
  assign w_b_load     = bus.up_sub ? ~bus.up_b : bus.up_b;
  assign w_carry_init = bus.up_sub;
`else
  assign w_b_load     = bus.up_b;
  assign w_carry_init = 1'b0;
`endif

  assign w_s       = fa_sum(r_a_sr[0], r_b_sr[0], r_carry);
  assign w_c       = fa_carry(r_a_sr[0], r_b_sr[0], r_carry);
  // The collector holds only the W-1 earlier bits; the final word appends the current bit.
  assign w_sum_cat = {w_s, r_sum_sr};

  // Next-state decode and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.up_valid) begin
          w_state_nxt = SHIFT;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        w_last = (r_cnt == CNT_LAST);
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      DONE: begin
        if (bus.down_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register with handshake flags registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_up_ready   <= 1'b1;
      r_down_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_up_ready   <= (w_state_nxt == IDLE);
      r_down_valid <= (w_state_nxt == DONE);
    end
  end

  // Operand shifters, carry, bit counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr       <= '0;
      r_b_sr       <= '0;
      r_sum_sr     <= '0;
      r_cnt        <= '0;
      r_carry      <= 1'b0;
      r_down_sum   <= '0;
      r_down_carry <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= bus.up_a;
      r_b_sr  <= w_b_load;
      r_carry <= w_carry_init;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_a_sr   <= {1'b0, r_a_sr[W-1:1]};
      r_b_sr   <= {1'b0, r_b_sr[W-1:1]};
      r_sum_sr <= w_sum_cat[W-1:1];
      r_carry  <= w_c;
      if (w_last) begin
        r_down_sum   <= w_sum_cat;
        r_down_carry <= w_c;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign bus.up_ready   = r_up_ready;
  assign bus.down_valid = r_down_valid;
  assign bus.down_sum   = r_down_sum;
  assign bus.down_carry = r_down_carry;
endmodule

// File: tb/tb_serial_word_adder.sv
// Directed plus randomized bench for serial_word_adder; expected results come from plain arithmetic.
module tb_serial_word_adder;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_word_adder_if #(.W(W)) bus ();

  serial_word_adder #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width sum, or difference with carry meaning "no borrow".
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W-1:0] d;
    if (sub) begin
      d = a - b;
      return {(a >= b), d};
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic set_sub(input logic sub);
`ifdef SERIAL_WORD_ADDER_SUB_EN
    bus.up_sub = sub;
`else
    if (sub) $display("note: subtraction requested without SERIAL_WORD_ADDER_SUB_EN");
`endif
  endtask

  // One full operation: present operands, measure latency, optional stall, drain.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                    input int stall, input logic poke);
    logic [W:0] exp;
    int         n;
    exp = model(a, b, sub);
    @(negedge clk);
    bus.up_valid   = 1'b1;
    bus.up_a       = a;
    bus.up_b       = b;
    set_sub(sub);
    bus.down_ready = (stall == 0);
    check("up_ready_idle", bus.up_ready, 1);
    @(posedge clk);
    n = 0;
    for (int k = 1; k <= 3 * W && n == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.up_valid = poke;
        bus.up_a     = poke ? 8'h11 : W'($urandom);
        bus.up_b     = poke ? 8'h22 : W'($urandom);
        set_sub(1'b0);
      end
      if (bus.down_valid === 1'b1) begin
        n = k;
        bus.up_valid = 1'b0;
      end else begin
        check("up_ready_busy", bus.up_ready, 0);
      end
    end
    check("latency", n, W + 1);
    check("sum", bus.down_sum, exp[W-1:0]);
    check("carry", bus.down_carry, exp[W]);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", bus.down_valid, 1);
      check("stall_sum", bus.down_sum, exp[W-1:0]);
      check("stall_up_ready", bus.up_ready, 0);
    end
    bus.down_ready = 1'b1;
    @(negedge clk);
    check("valid_drop", bus.down_valid, 0);
    check("up_ready_back", bus.up_ready, 1);
    check("sum_hold", bus.down_sum, exp[W-1:0]);
    check("carry_hold", bus.down_carry, exp[W]);
    bus.down_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst            = 1'b1;
    bus.up_valid   = 1'b0;
    bus.up_a       = '0;
    bus.up_b       = '0;
    bus.down_ready = 1'b0;
    set_sub(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_up_ready", bus.up_ready, 1);
    check("rst_valid", bus.down_valid, 0);
    check("rst_sum", bus.down_sum, 0);
    check("rst_carry", bus.down_carry, 0);
    rst = 1'b0;

    op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    op(8'h00, 8'h00, 1'b0, 0, 1'b0);
    op(8'h5A, 8'h3C, 1'b0, 5, 1'b0);
    op(8'h5A, 8'h3C, 1'b0, 0, 1'b1);
    op(8'h11, 8'h22, 1'b0, 0, 1'b0);

    // Reset in the 4th SHIFT cycle with a nonzero result (0x33) still on down_sum
    @(negedge clk);
    bus.up_valid = 1'b1;
    bus.up_a     = 8'hA5;
    bus.up_b     = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    bus.up_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_up_ready", bus.up_ready, 1);
    check("mid_rst_valid", bus.down_valid, 0);
    check("mid_rst_sum", bus.down_sum, 0);
    check("mid_rst_carry", bus.down_carry, 0);
    op(8'h0F, 8'h01, 1'b0, 0, 1'b0);

`ifdef SERIAL_WORD_ADDER_SUB_EN
    op(8'h10, 8'h20, 1'b1, 0, 1'b0);
    op(8'h20, 8'h10, 1'b1, 0, 1'b0);
    op(8'h20, 8'h10, 1'b0, 0, 1'b0);
`endif

    for (int r = 0; r < 20; r++) begin
`ifdef SERIAL_WORD_ADDER_SUB_EN
      op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
`else
      op(W'($urandom), W'($urandom), 1'b0, $urandom_range(0, 2), 1'b0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
